// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// Start/done handshake; sum and cout update only on the completion edge.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;

    logic s_bit;
    logic c_nxt;
    logic accept;
    logic last_bit;

    assign s_bit    = a_sr[0] ^ b_sr[0] ^ c;
    assign c_nxt    = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == SHIFT) && (cnt == LAST);

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, one bit of addition per cycle, counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            res  <= '0;
            cnt  <= '0;
            c    <= 1'b0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            cnt  <= '0;
            c    <= 1'b0;
        end else if (state == SHIFT) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            res  <= {s_bit, res[WIDTH-1:1]};
            c    <= c_nxt;
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Publish the result only when the last bit has been added
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= {s_bit, res[WIDTH-1:1]};
            cout <= c_nxt;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed and random additions checked
// against plain integer addition.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total;
    int bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full addition from IDLE; operands are scrambled after acceptance
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   e;
        logic [W-1:0] prev;
        int           n;
        e    = {1'b0, x} + {1'b0, y};
        prev = sum;
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk("busy_e0", 32'(busy), 1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) begin
                chk("busy_shift", 32'(busy), 1);
                chk("sum_hold", 32'(sum), 32'(prev));
            end
        end
        chk("latency", n, W);
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
        chk("busy_at_done", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 0);
        chk("sum_keep", 32'(sum), 32'(e[W-1:0]));
    endtask

    initial begin
        int ndone;
        int k;
        int k1;
        int k2;
        logic [W-1:0] s1;
        logic [W-1:0] s2;
        logic [W-1:0] first_sum;

        total = 0;
        bad   = 0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        rst   = 1'b1;
        #1;
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(8'd3, 8'd5);
        do_op(8'd200, 8'd100);
        do_op(8'd255, 8'd1);
        do_op(8'd0, 8'd0);

        // start pulsed while busy must be ignored
        @(negedge clk);
        a = 8'd50;
        b = 8'd60;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd1;
        b = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        first_sum = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (ndone == 0) first_sum = sum;
                ndone++;
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_sum", 32'(first_sum), 110);

        // reset in the middle of an addition
        @(negedge clk);
        a = 8'd100;
        b = 8'd27;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_cout", 32'(cout), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid_rst_nodone", ndone, 0);
        do_op(8'd100, 8'd27);

        // start held high: back-to-back re-acceptance
        @(negedge clk);
        a = 8'd10;
        b = 8'd20;
        start = 1'b1;
        @(posedge clk);
        k  = 0;
        k1 = -1;
        k2 = -1;
        s1 = '0;
        s2 = '0;
        while (k2 < 0 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                if (k1 < 0) begin
                    k1 = k;
                    s1 = sum;
                    b = 8'd30;
                end else begin
                    k2 = k;
                    s2 = sum;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held_k1", k1, 8);
        chk("held_s1", 32'(s1), 30);
        chk("held_k2", k2, 18);
        chk("held_s2", 32'(s2), 40);
        repeat (3) @(posedge clk);
        #1;
        chk("held_idle", 32'(busy), 0);

        for (int i = 0; i < 12; i++) begin
            do_op(W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
